// File: rtl/pic_priority_ack_ctrl.sv
// rtl/pic_priority_ack_ctrl.sv - 8259 priority resolver, INTA sequencer, ISR and EOI handling
module pic_priority_ack_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irr,
    input  logic [7:0] imr,
    input  logic [4:0] vector_base,
    input  logic       aeoi,
    input  logic       rotate,
    input  logic       eoi_ns,
    input  logic       eoi_sp,
    input  logic [2:0] eoi_level,
    input  logic       inta,
    output logic       int_req,
    output logic [2:0] ack_idx,
    output logic       ack_pulse,
    output logic [7:0] isr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2, DRIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] inta_sync_q;
    logic                   inta_prev_q;
    logic                   inta_s, inta_rise, inta_fall;
    logic [2:0]             lowest_prio_q, lowest_prio_d;
    logic [7:0]             isr_q, isr_d, isr_set, isr_clr;
    logic [2:0]             idx_q, idx_d;
    logic                   idx_valid_q, idx_valid_d;
    logic                   int_req_q, int_req_d;
    logic [2:0]             ack_idx_q, ack_idx_d;
    logic                   ack_pulse_q, ack_pulse_d;
    logic [7:0]             data_out_q, data_out_d;
    logic                   data_oe_q, data_oe_d;

    logic [2:0] shift;
    logic [3:0] req_pos, isr_pos;
    logic       cand_valid, hi_valid;
    logic [2:0] cand_idx, hi_idx;

    // Rotate so bit 0 holds the highest-priority level, then the lowest set bit wins.
    function automatic logic [7:0] rot8(input logic [7:0] v, input logic [2:0] sh);
        logic [15:0] dbl;
        dbl  = {v, v} >> sh;
        rot8 = dbl[7:0];
    endfunction

    function automatic logic [3:0] first_set(input logic [7:0] v);
        first_set = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) first_set = 4'(i);
        end
    endfunction

    assign shift      = lowest_prio_q + 3'd1;
    assign req_pos    = first_set(rot8(irr & ~imr, shift));
    assign isr_pos    = first_set(rot8(isr_q, shift));
    assign cand_valid = (req_pos != 4'd8) && (req_pos < isr_pos);
    assign cand_idx   = req_pos[2:0] + shift;
    assign hi_valid   = (isr_pos != 4'd8);
    assign hi_idx     = isr_pos[2:0] + shift;

    assign inta_s    = inta_sync_q[SYNC_STAGES-1];
    assign inta_rise = inta_s & ~inta_prev_q;
    assign inta_fall = ~inta_s & inta_prev_q;

    // Synchronizer resets high so an inta still asserted across reset cannot fake a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inta_sync_q <= '1;
            inta_prev_q <= 1'b1;
        end else begin
            inta_sync_q <= {inta_sync_q[SYNC_STAGES-2:0], inta};
            inta_prev_q <= inta_s;
        end
    end

    always_comb begin
        state_d       = state_q;
        isr_set       = '0;
        isr_clr       = '0;
        lowest_prio_d = lowest_prio_q;
        idx_d         = idx_q;
        idx_valid_d   = idx_valid_q;
        int_req_d     = 1'b0;
        ack_idx_d     = ack_idx_q;
        ack_pulse_d   = 1'b0;
        data_out_d    = data_out_q;
        data_oe_d     = data_oe_q;

        if (eoi_sp) begin
            isr_clr[eoi_level] = 1'b1;
        end else if (eoi_ns && hi_valid) begin
            isr_clr[hi_idx] = 1'b1;
            if (rotate) lowest_prio_d = hi_idx;
        end

        case (state_q)
            IDLE: begin
                if (inta_rise) begin
                    state_d     = ACK1;
                    idx_d       = cand_valid ? cand_idx : 3'd7;
                    idx_valid_d = cand_valid;
                    if (cand_valid) begin
                        isr_set[cand_idx] = 1'b1;
                        ack_pulse_d       = 1'b1;
                        ack_idx_d         = cand_idx;
                    end
                end else begin
                    int_req_d = cand_valid;
                end
            end
            ACK1: if (inta_fall) state_d = ACK2;
            ACK2: begin
                if (inta_rise) begin
                    state_d    = DRIVE;
                    data_out_d = {vector_base, idx_q};
                    data_oe_d  = 1'b1;
                end
            end
            DRIVE: begin
                if (inta_fall) begin
                    state_d   = IDLE;
                    data_oe_d = 1'b0;
                    if (aeoi && idx_valid_q) begin
                        isr_clr[idx_q] = 1'b1;
                        if (rotate) lowest_prio_d = idx_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        isr_d = (isr_q & ~isr_clr) | isr_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lowest_prio_q <= 3'd7;
            isr_q         <= '0;
            idx_q         <= 3'd7;
            idx_valid_q   <= 1'b0;
            int_req_q     <= 1'b0;
            ack_idx_q     <= '0;
            ack_pulse_q   <= 1'b0;
            data_out_q    <= '0;
            data_oe_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lowest_prio_q <= lowest_prio_d;
            isr_q         <= isr_d;
            idx_q         <= idx_d;
            idx_valid_q   <= idx_valid_d;
            int_req_q     <= int_req_d;
            ack_idx_q     <= ack_idx_d;
            ack_pulse_q   <= ack_pulse_d;
            data_out_q    <= data_out_d;
            data_oe_q     <= data_oe_d;
        end
    end

    assign int_req   = int_req_q;
    assign ack_idx   = ack_idx_q;
    assign ack_pulse = ack_pulse_q;
    assign isr       = isr_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;

endmodule

// File: tb/tb_pic_priority_ack_ctrl.sv
// tb/tb_pic_priority_ack_ctrl.sv - directed and random checks of pic_priority_ack_ctrl against a level-scan model
module tb_pic_priority_ack_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irr = '0;
    logic [7:0] imr = '0;
    logic [4:0] vector_base = 5'h11;
    logic       aeoi = 1'b0;
    logic       rotate = 1'b0;
    logic       eoi_ns = 1'b0;
    logic       eoi_sp = 1'b0;
    logic [2:0] eoi_level = '0;
    logic       inta = 1'b0;
    logic       int_req;
    logic [2:0] ack_idx;
    logic       ack_pulse;
    logic [7:0] isr;
    logic [7:0] data_out;
    logic       data_oe;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ack_cnt = 0;
    int         last_ack = -1;
    logic [7:0] m_isr = '0;
    int         m_lp = 7;
    int         e, c0;

    pic_priority_ack_ctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .irr(irr), .imr(imr), .vector_base(vector_base),
        .aeoi(aeoi), .rotate(rotate), .eoi_ns(eoi_ns), .eoi_sp(eoi_sp),
        .eoi_level(eoi_level), .inta(inta), .int_req(int_req), .ack_idx(ack_idx),
        .ack_pulse(ack_pulse), .isr(isr), .data_out(data_out), .data_oe(data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack_pulse === 1'b1) begin
            ack_cnt  = ack_cnt + 1;
            last_ack = int'(ack_idx);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Walk levels from highest priority down; an in-service level blocks everything at or below it.
    function automatic int model_cand(input logic [7:0] r, input logic [7:0] m);
        for (int p = 1; p <= 8; p++) begin
            int lvl;
            lvl = (m_lp + p) % 8;
            if (m_isr[lvl]) return -1;
            if (r[lvl] && !m[lvl]) return lvl;
        end
        return -1;
    endfunction

    function automatic int model_hi_isr();
        for (int p = 1; p <= 8; p++) begin
            int lvl;
            lvl = (m_lp + p) % 8;
            if (m_isr[lvl]) return lvl;
        end
        return -1;
    endfunction

    task automatic check_int(input string tag);
        wait_cyc(3);
        check(tag, int'(int_req), (model_cand(irr, imr) >= 0) ? 1 : 0);
    endtask

    task automatic ack_first(output int idx);
        int exp, cnt0;
        exp  = model_cand(irr, imr);
        cnt0 = ack_cnt;
        inta = 1'b1;
        wait_cyc(5);
        check("ack_count", ack_cnt - cnt0, (exp >= 0) ? 1 : 0);
        if (exp >= 0) begin
            check("ack_idx", last_ack, exp);
            m_isr[exp] = 1'b1;
        end
        check("isr_ack1", int'(isr), int'(m_isr));
        check("int_req_ack1", int'(int_req), 0);
        idx = exp;
    endtask

    task automatic ack_second(input int exp, input bit scramble);
        logic [7:0] ed;
        if (scramble) irr = 8'($urandom);
        ed   = {vector_base, (exp >= 0) ? 3'(exp) : 3'd7};
        inta = 1'b0;
        wait_cyc(5);
        inta = 1'b1;
        wait_cyc(5);
        check("data_oe_drive", int'(data_oe), 1);
        check("data_out", int'(data_out), int'(ed));
        check("isr_drive", int'(isr), int'(m_isr));
        inta = 1'b0;
        wait_cyc(5);
        check("data_oe_idle", int'(data_oe), 0);
        if (aeoi && exp >= 0) begin
            m_isr[exp] = 1'b0;
            if (rotate) m_lp = exp;
        end
        check("isr_done", int'(isr), int'(m_isr));
    endtask

    task automatic do_eoi(input bit ns, input bit sp, input logic [2:0] lvl);
        int h;
        eoi_ns    = ns;
        eoi_sp    = sp;
        eoi_level = lvl;
        wait_cyc(1);
        eoi_ns = 1'b0;
        eoi_sp = 1'b0;
        wait_cyc(2);
        if (sp) begin
            m_isr[lvl] = 1'b0;
        end else if (ns) begin
            h = model_hi_isr();
            if (h >= 0) begin
                m_isr[h] = 1'b0;
                if (rotate) m_lp = h;
            end
        end
        check("isr_eoi", int'(isr), int'(m_isr));
    endtask

    initial begin
        wait_cyc(3);
        check("rst_int_req", int'(int_req), 0);
        check("rst_ack_idx", int'(ack_idx), 0);
        check("rst_ack_pulse", int'(ack_pulse), 0);
        check("rst_isr", int'(isr), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_data_oe", int'(data_oe), 0);
        reset = 1'b0;

        // Basic acknowledge: IR2 beats IR5
        irr = 8'h24;
        check_int("t1_int_req");
        ack_first(e);
        check("t1_idx", e, 2);
        ack_second(e, 1'b0);
        check("t1_isr", int'(isr), 8'h04);

        // Fully nested: lower level blocked, higher level nests
        irr = 8'h08;
        check_int("t2_blocked");
        irr = 8'h01;
        check_int("t2_nest_int");
        ack_first(e);
        ack_second(e, 1'b0);
        check("t2_isr", int'(isr), 8'h05);
        do_eoi(1'b1, 1'b0, 3'd0);
        check("t2_eoi", int'(isr), 8'h04);
        do_eoi(1'b0, 1'b1, 3'd2);

        // AEOI with rotation moves IR0 to lowest priority
        aeoi   = 1'b1;
        rotate = 1'b1;
        irr    = 8'h01;
        check_int("t3_int");
        ack_first(e);
        ack_second(e, 1'b0);
        irr = 8'h03;
        check_int("t3_int2");
        ack_first(e);
        check("t3_idx_rot", e, 1);
        ack_second(e, 1'b0);

        // Spurious: request withdrawn before the first inta pulse
        irr = 8'h10;
        check_int("t4_int");
        irr = 8'h00;
        ack_first(e);
        ack_second(e, 1'b0);

        // Specific EOI on the same level and cycle as the ISR set: set wins
        aeoi   = 1'b0;
        rotate = 1'b0;
        irr    = 8'h20;
        wait_cyc(3);
        e    = model_cand(irr, imr);
        c0   = ack_cnt;
        inta = 1'b1;
        wait_cyc(2);
        eoi_sp    = 1'b1;
        eoi_level = 3'd5;
        wait_cyc(1);
        eoi_sp = 1'b0;
        wait_cyc(2);
        check("t5_ack_count", ack_cnt - c0, 1);
        check("t5_ack_idx", last_ack, 5);
        m_isr[5] = 1'b1;
        check("t5_isr", int'(isr), int'(m_isr));
        ack_second(e, 1'b0);
        do_eoi(1'b0, 1'b1, 3'd5);

        // Reset during DRIVE, then the trailing inta fall must be ignored
        irr = 8'h02;
        wait_cyc(3);
        ack_first(e);
        inta = 1'b0;
        wait_cyc(5);
        inta = 1'b1;
        wait_cyc(5);
        check("t6_pre_oe", int'(data_oe), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_oe", int'(data_oe), 0);
        check("t6_rst_isr", int'(isr), 0);
        check("t6_rst_int", int'(int_req), 0);
        wait_cyc(2);
        reset = 1'b0;
        m_isr = '0;
        m_lp  = 7;
        wait_cyc(3);
        c0   = ack_cnt;
        inta = 1'b0;
        wait_cyc(5);
        check("t6_fall_ack", ack_cnt - c0, 0);
        check("t6_fall_oe", int'(data_oe), 0);
        check("t6_idle_int", int'(int_req), 1);
        ack_first(e);
        ack_second(e, 1'b0);

        for (int it = 0; it < 40; it++) begin
            irr         = 8'($urandom);
            imr         = 8'($urandom & $urandom & $urandom);
            vector_base = 5'($urandom);
            aeoi        = 1'($urandom);
            rotate      = 1'($urandom);
            check_int("rnd_int_req");
            ack_first(e);
            ack_second(e, 1'($urandom));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                case ($urandom_range(0, 2))
                    0:       do_eoi(1'b1, 1'b0, 3'd0);
                    1:       do_eoi(1'b0, 1'b1, 3'($urandom));
                    default: do_eoi(1'b1, 1'b1, 3'($urandom));
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
